cla_seq_ctrl: RTL
=================

# cla_seq_ctrl

Multi-cycle sequencer that adds or subtracts two wide operands using one `cla_adder` of NBIT bits. It processes one NBIT-bit word per clock, least significant word first, and chains the carry through a register. It sits between a requester that supplies NWORDS×NBIT-bit operands and the shared narrow adder datapath. Control is a start/busy/done handshake with latched operands.

## Interface
- NBIT, 11, word width; passed to the `cla_adder` instance
- NWORDS, 4, number of words per operand; must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = a+b+cin, 1 = a−b (b inverted, cin forced 1); latched on accept
- cin  input  1  carry-in for add; ignored when sub=1; latched on accept
- a  input  NBIT*NWORDS  operand A; latched on accept
- b  input  NBIT*NWORDS  operand B; latched on accept
- busy  output  1  high while words are being processed
- done  output  1  one-cycle pulse; s and cout are valid
- s  output  NBIT*NWORDS  result, held from done until the next accept
- cout  output  1  final carry; for sub, 1 = no borrow

## Operation
- States are IDLE, RUN and DONE. After reset the state is IDLE, busy=0, done=0, s=0, cout=0, the word index is 0 and the carry register is 0.
- Accept: start=1 in IDLE or DONE latches a, b (b inverted when sub=1), the carry register (cin, or 1 when sub=1) and clears the index. Next state is RUN.
- RUN, one word per cycle:
  - Word idx of the latched a and b drives the adder. The carry register drives the adder's cin.
  - The adder sum is written to s[idx*NBIT +: NBIT].
  - The carry register takes the word carry, then idx increments.
- Word carry = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb), using the MSBs of the adder inputs and the adder sum. The adder instance's own cout port is left unconnected.
- When idx = NWORDS−1 is processed, cout takes the word carry and the next state is DONE.
- DONE lasts one cycle with done=1. Next state is RUN if start=1, otherwise IDLE.
- start in RUN is ignored and not queued. Inputs a, b, sub and cin may change freely after accept.
- s words not yet rewritten in a new operation keep their old values until overwritten. Consumers use s only while done=1 or afterwards, before the next accept.
- rst=1 in any state, including mid-RUN, forces the reset values on the next edge. The partial result is discarded.

## Timing
- Accept at edge E0 gives busy=1 from E0 to EN (N = NWORDS). Word k is written at edge E(k+1).
- done=1 in the cycle after EN, i.e. N cycles after accept; busy=0 in that same cycle.
- Throughput: one operation per N+1 cycles, including back-to-back accepts in DONE.
- The adder path is purely combinational inside one cycle. There is no extra pipeline stage.
- busy and done are registered outputs, never high together.

## Structure
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default NBIT and NWORDS, and an index width function clog2(NWORDS).
- One sub-module: `cla_adder` with NBIT passed through, instantiated once. All sequencing and carry logic live in `cla_seq_ctrl`.

## Test plan
All scenarios use NBIT=11 and NWORDS=4, so operands are 44 bits.
- Full carry ripple: a=0xFFFFFFFFFFF, b=1, sub=0, cin=0. Expect s=0x00000000000, cout=1, done exactly 4 cycles after accept.
- Subtract with borrow: a=5, b=7, sub=1. Expect s=0xFFFFFFFFFFE, cout=0. Then a=7, b=5 gives s=2, cout=1.
- Carry-in only: a=0, b=0, cin=1. Expect s=1, cout=0.
- Busy lockout: pulse start with new operands while busy=1. Expect the first result to be unchanged, only one done pulse, and busy=0 after done.
- Reset mid-op: assert rst while the index is 2. On the next edge expect busy=0, done=0, s=0, cout=0. No done pulse follows.
- Back-to-back: hold start=1 during the done cycle with a=0x123, b=0x456. Expect busy=1 the next cycle and done 4 cycles later with s=0x579.

Source files
------------

// File: rtl/cla_seq_ctrl_pkg.sv
// Shared definitions for the word-serial add/subtract sequencer.
package cla_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NBIT_DEF   = 11;
  localparam int NWORDS_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_seq_ctrl_adder.sv
// NBIT-wide adder built from generate/propagate terms.
module cla_adder #(
  parameter int NBIT = 11
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  output logic [NBIT-1:0] s,
  output logic            cout
);

  logic [NBIT-1:0] g;
  logic [NBIT-1:0] p;
  logic [NBIT:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NBIT; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s    = p ^ c[NBIT-1:0];
  assign cout = c[NBIT];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-word add/subtract: one NBIT word per clock, LSW first,
// carry chained through a register.
module cla_seq_ctrl
  import cla_seq_ctrl_pkg::*;
#(
  parameter int NBIT   = NBIT_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [NBIT*NWORDS-1:0] a,
  input  logic [NBIT*NWORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [NBIT*NWORDS-1:0] s,
  output logic                   cout
);

  localparam int IW = clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t                 state;
  logic [IW-1:0]          idx;
  logic                   cr;
  logic [NBIT*NWORDS-1:0] a_q;
  logic [NBIT*NWORDS-1:0] b_q;

  logic [NBIT-1:0] wa;
  logic [NBIT-1:0] wb;
  logic [NBIT-1:0] sum;
  logic            wc;

  assign wa = a_q[idx*NBIT +: NBIT];
  assign wb = b_q[idx*NBIT +: NBIT];

  cla_adder #(
    .NBIT(NBIT)
  ) u_add (
    .a   (wa),
    .b   (wb),
    .cin (cr),
    .s   (sum),
    .cout()
  );

  // Carry recovered from MSBs so the adder's own cout stays unused
  assign wc = (wa[NBIT-1] & wb[NBIT-1]) |
              ((wa[NBIT-1] ^ wb[NBIT-1]) & ~sum[NBIT-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      idx   <= '0;
      cr    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            cr    <= sub | cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          s[idx*NBIT +: NBIT] <= sum;
          cr  <= wc;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout  <= wc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
